// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle for the pipelined data memory.
// master drives requests and takes responses; slave is the memory.
interface data_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [BYTES-1:0]  req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_pipelined.sv
// data_mem_pipelined: byte-enabled data memory with configurable read
// latency, in-order credit-managed response FIFO and range-error flag.
module data_mem_pipelined #(
  parameter int DATA_W     = 32,
  parameter int NUM_WORDS  = 8192,
  parameter int ADDR_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic       clock_mem,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IW    = $clog2(NUM_WORDS);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } ent_t;

  logic [DATA_W-1:0] mem    [NUM_WORDS];
  logic [DATA_W:0]   fifo_q [FIFO_DEPTH];

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     credits;
  logic [IW-1:0]     idx;
  logic              oob;
  logic              accept;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] merged;
  logic [DATA_W:0]   head;
  ent_t              ent_in;
  ent_t              ent_out;

  assign idx           = bus.req_addr[LSB+IW-1:LSB];
  assign oob           = |bus.req_addr[ADDR_W-1:LSB+IW];
  assign bus.req_ready = !rst && (credits < CW'(FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // Write-first: response carries the stored word with this request's lanes
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < BYTES; i++) begin
      if (bus.req_we[i]) merged[8*i +: 8] = bus.req_wdata[8*i +: 8];
    end
  end

  assign ent_in = '{valid: accept,
                    err:   oob,
                    rdata: oob ? '0 : merged};

  // Storage is deliberately not reset so contents survive rst
  always_ff @(posedge clock_mem) begin
    if (accept && !oob) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.req_we[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign ent_out = ent_in;
    end else begin : g_latn
      ent_t pipe [READ_LAT-1];
      always_ff @(posedge clock_mem or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < READ_LAT - 1; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= ent_in;
          for (int k = 1; k < READ_LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign ent_out = pipe[READ_LAT-2];
    end
  endgenerate

  generate
    if (LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^bus.req_addr[LSB-1:0];
    end
  endgenerate

  assign push = ent_out.valid;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock_mem) begin
    if (push) fifo_q[wptr] <= {ent_out.err, ent_out.rdata};
  end

  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      credits <= '0;
    end else begin
      if (push) wptr <= bump(wptr);
      if (pop)  rptr <= bump(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign head          = fifo_q[rptr];
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_rdata = bus.rsp_valid ? head[DATA_W-1:0] : '0;
  assign bus.rsp_err   = bus.rsp_valid & head[DATA_W];
endmodule

// File: tb/tb_data_mem_pipelined.sv
// tb_data_mem_pipelined: directed checks of the pipelined data memory,
// default build plus a READ_LAT=3 build for backpressure.
module tb_data_mem_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_if a_if ();
  data_mem_if b_if ();

  data_mem_pipelined u_dut_a (
    .clock_mem (clk),
    .rst       (rst),
    .bus       (a_if.slave)
  );

  data_mem_pipelined #(
    .READ_LAT   (3),
    .FIFO_DEPTH (4)
  ) u_dut_b (
    .clock_mem (clk),
    .rst       (rst),
    .bus       (b_if.slave)
  );

  logic [32:0] exp_q [$];
  logic [31:0] model [int unsigned];
  logic [32:0] e;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [3:0] we,
                          input logic [31:0] wdata);
    logic [31:0]  w;
    int unsigned  i;
    if (|addr[31:15]) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      i = {19'd0, addr[14:2]};
      w = model.exists(i) ? model[i] : 32'h0;
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model[i] = w;
      exp_q.push_back({1'b0, w});
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wdata, input logic rdy);
    int n;
    @(negedge clk);
    a_if.req_valid = 1'b1;
    a_if.req_addr  = addr;
    a_if.req_we    = we;
    a_if.req_wdata = wdata;
    a_if.rsp_ready = rdy;
    n = 0;
    while (!a_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_if.req_ready) begin
      check("req_timeout", 64'd0, 64'd1);
      a_if.req_valid = 1'b0;
      return;
    end
    push_exp(addr, we, wdata);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    #4;
    if (!rst && a_if.rsp_valid && a_if.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("stale_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rdata", {32'd0, a_if.rsp_rdata}, {32'd0, e[31:0]});
        check("sb_err", {63'd0, a_if.rsp_err}, {63'd0, e[32]});
      end
    end
  end

  initial begin
    int n_acc;
    int n;
    logic acc;
    a_if.req_valid = 1'b0;
    a_if.req_addr  = '0;
    a_if.req_we    = '0;
    a_if.req_wdata = '0;
    a_if.rsp_ready = 1'b1;
    b_if.req_valid = 1'b0;
    b_if.req_addr  = '0;
    b_if.req_we    = '0;
    b_if.req_wdata = '0;
    b_if.rsp_ready = 1'b1;

    #3;
    check("rst_req_ready", {63'd0, a_if.req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, a_if.rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, a_if.rsp_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_req_ready", {63'd0, a_if.req_ready}, 64'd1);

    // 1: defaults
    do_req(32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
    do_req(32'h10, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("t1_rsp_valid", {63'd0, a_if.rsp_valid}, 64'd1);
    check("t1_rdata", {32'd0, a_if.rsp_rdata}, 64'hDEADBEEF);
    a_if.req_valid = 1'b0;

    // 2: byte lanes
    do_req(32'h20, 4'hF, 32'h11223344, 1'b1);
    do_req(32'h20, 4'b0101, 32'hAABBCCDD, 1'b1);
    @(negedge clk);
    check("t2_wr_rsp", {32'd0, a_if.rsp_rdata}, 64'h11BB33DD);
    a_if.req_valid = 1'b0;
    do_req(32'h20, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("t2_rd_rsp", {32'd0, a_if.rsp_rdata}, 64'h11BB33DD);
    a_if.req_valid = 1'b0;

    // 4: out of range
    do_req(32'h0, 4'hF, 32'h12345678, 1'b1);
    do_req(32'h0000_8000, 4'hF, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check("t4_err", {63'd0, a_if.rsp_err}, 64'd1);
    check("t4_rdata", {32'd0, a_if.rsp_rdata}, 64'd0);
    a_if.req_valid = 1'b0;
    do_req(32'h0, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("t4_addr0", {32'd0, a_if.rsp_rdata}, 64'h12345678);
    a_if.req_valid = 1'b0;

    // 5: hazard and wrap-around
    do_req(32'h40, 4'hF, 32'h5, 1'b1);
    do_req(32'h40, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("t5_hazard", {32'd0, a_if.rsp_rdata}, 64'h5);
    a_if.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] we;
      we = (i < 4) ? 4'hF : ((i % 3 == 0) ? 4'h0 :
           ((i % 3 == 1) ? 4'b0011 : 4'b1100));
      do_req(32'h100 + 32'(i % 4) * 4, we,
             32'h01010101 * 32'(i) ^ 32'hA5C3_0F96, (i % 4) != 3);
    end
    @(negedge clk);
    a_if.req_valid = 1'b0;
    a_if.rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_drain", 64'(exp_q.size()), 64'd0);

    // 3: backpressure on the READ_LAT=3 build
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_if.req_valid = 1'b1;
      b_if.req_addr  = 32'(i) * 4;
      b_if.req_we    = 4'hF;
      b_if.req_wdata = 32'hB0 + 32'(i);
      n = 0;
      while (!b_if.req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t3_wr_ready", {63'd0, b_if.req_ready}, 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    b_if.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    b_if.rsp_ready = 1'b0;
    b_if.req_valid = 1'b1;
    b_if.req_we    = 4'h0;
    b_if.req_addr  = 32'h0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      acc = b_if.req_ready;
      @(posedge clk);
      if (acc) n_acc++;
      @(negedge clk);
      b_if.req_addr = 32'(n_acc) * 4;
    end
    check("t3_accepts", 64'(n_acc), 64'd4);
    check("t3_ready_low", {63'd0, b_if.req_ready}, 64'd0);
    b_if.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    b_if.rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("t3_order", {32'd0, b_if.rsp_rdata}, 64'hB0 + 64'(j));
      if (j == 1) check("t3_ready_back", {63'd0, b_if.req_ready}, 64'd1);
      @(negedge clk);
    end
    check("t3_empty", {63'd0, b_if.rsp_valid}, 64'd0);

    // 6: reset mid-operation
    do_req(32'h10, 4'h0, 32'h0, 1'b0);
    do_req(32'h20, 4'h0, 32'h0, 1'b0);
    do_req(32'h40, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    check("t6_buffered", {63'd0, a_if.rsp_valid}, 64'd1);
    check("t6_head", {32'd0, a_if.rsp_rdata}, 64'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rsp_drop", {63'd0, a_if.rsp_valid}, 64'd0);
    check("t6_ready_rst", {63'd0, a_if.req_ready}, 64'd0);
    check("t6_rdata_rst", {32'd0, a_if.rsp_rdata}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    a_if.rsp_ready = 1'b1;
    #1;
    check("t6_ready_rel", {63'd0, a_if.req_ready}, 64'd1);
    repeat (3) @(negedge clk);
    check("t6_no_stale", {63'd0, a_if.rsp_valid}, 64'd0);
    do_req(32'h10, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("t6_persist", {32'd0, a_if.rsp_rdata}, 64'hDEADBEEF);
    a_if.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
